sim_timer_dev: RTL and testbench

- Memory-mapped machine-timer device for the compliance/simulation top level.
- Attaches as a device port on the simulation bus, next to the RAM and the test utility, and drives the core's irq_timer_i input.
- Provides a 64-bit mtime counter with a prescaler, a 64-bit mtimecmp compare register and a level timer interrupt.
- Lets compliance and interrupt tests run without external stimulus.

---
 rtl/sim_timer_dev_pkg.sv | 27 ++
 rtl/sim_timer_dev_tick.sv | 34 +++
 rtl/sim_timer_dev.sv | 182 ++++++++++++++++++
 tb/tb_sim_timer_dev.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_timer_dev_pkg.sv
// Shared definitions for the simulation machine-timer device: register
// offsets inside the 1 kB window, CTRL bit positions and byte-enable merge.
package sim_timer_dev_pkg;

    typedef enum logic [9:0] {
        OFF_MTIME_LO    = 10'h000,
        OFF_MTIME_HI    = 10'h004,
        OFF_MTIMECMP_LO = 10'h008,
        OFF_MTIMECMP_HI = 10'h00C,
        OFF_PRESCALE    = 10'h010,
        OFF_CTRL        = 10'h014
    } reg_off_e;

    localparam int CTRL_EN_BIT = 0;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sim_timer_dev_tick.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick whenever the
// count reaches the prescale limit, so mtime advances every prescale+1 cycles.
module sim_timer_dev_tick
    import sim_timer_dev_pkg::*;
#(
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [PrescaleWidth-1:0] prescale_i,
    input  logic                     clr_i,
    output logic                     tick_o
);

    logic [PrescaleWidth-1:0] cnt;
    logic                     at_limit;

    assign at_limit = (cnt == prescale_i);
    // A prescale write restarts the period, so no tick is issued in that cycle.
    assign tick_o   = en_i && !clr_i && at_limit;

    // Count enabled cycles, wrapping to zero on the tick; hold while disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= at_limit ? '0 : cnt + PrescaleWidth'(1);
        end
    end

endmodule

// File: rtl/sim_timer_dev.sv
// Memory-mapped machine timer for the simulation bus: 64-bit mtime with
// prescaler, mtimecmp compare and a registered level interrupt.
module sim_timer_dev
    import sim_timer_dev_pkg::*;
#(
    parameter int unsigned          TimeWidth     = 64,
    parameter int unsigned          PrescaleWidth = 16,
    parameter logic [TimeWidth-1:0] CmpResetVal   = '1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [31:0] dev_addr_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,
    output logic        timer_irq_o
);

    localparam int unsigned HiWidth = TimeWidth - 32;

    logic [TimeWidth-1:0]     mtime;
    logic [TimeWidth-1:0]     mtimecmp;
    logic [HiWidth-1:0]       hi_shadow;
    logic [PrescaleWidth-1:0] prescale;
    logic                     ctrl_en;
    logic                     tick;

    logic [9:0]  off;
    logic        hit;
    logic        rd_act;
    logic        wr_act;
    logic [31:0] rd_word;
    logic [31:0] old_word;
    logic [31:0] wmerge;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_prescale, wr_ctrl;

    logic        vld_p1;
    logic        err_p1;
    logic [31:0] rdata_p1;
    logic        irq_p1;

    logic        unused_bits;

    assign off = dev_addr_i[9:0];

    // Decode the offset: read value (HI word comes from the shadow) and the
    // current live word used as the base for byte-granular writes.
    always_comb begin
        hit      = 1'b0;
        rd_word  = '0;
        old_word = '0;
        case (off)
            OFF_MTIME_LO: begin
                hit      = 1'b1;
                rd_word  = mtime[31:0];
                old_word = mtime[31:0];
            end
            OFF_MTIME_HI: begin
                hit      = 1'b1;
                rd_word  = 32'(hi_shadow);
                old_word = 32'(mtime[TimeWidth-1:32]);
            end
            OFF_MTIMECMP_LO: begin
                hit      = 1'b1;
                rd_word  = mtimecmp[31:0];
                old_word = mtimecmp[31:0];
            end
            OFF_MTIMECMP_HI: begin
                hit      = 1'b1;
                rd_word  = 32'(mtimecmp[TimeWidth-1:32]);
                old_word = 32'(mtimecmp[TimeWidth-1:32]);
            end
            OFF_PRESCALE: begin
                hit      = 1'b1;
                rd_word  = 32'(prescale);
                old_word = 32'(prescale);
            end
            OFF_CTRL: begin
                hit      = 1'b1;
                rd_word  = {31'b0, ctrl_en};
                old_word = {31'b0, ctrl_en};
            end
            default: ;
        endcase
    end

    assign wmerge = apply_be(old_word, dev_wdata_i, dev_be_i);

    // A write with no byte enabled touches nothing, not even the prescaler.
    assign wr_act = dev_req_i && dev_we_i && hit && (|dev_be_i);
    assign rd_act = dev_req_i && !dev_we_i && hit;

    assign wr_mtime_lo = wr_act && (off == OFF_MTIME_LO);
    assign wr_mtime_hi = wr_act && (off == OFF_MTIME_HI);
    assign wr_cmp_lo   = wr_act && (off == OFF_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_act && (off == OFF_MTIMECMP_HI);
    assign wr_prescale = wr_act && (off == OFF_PRESCALE);
    assign wr_ctrl     = wr_act && (off == OFF_CTRL);

    // Upper address bits are outside the decoded window; unimplemented
    // write-data bits of narrow registers are dropped.
    assign unused_bits = ^{dev_addr_i[31:10], wmerge};

    sim_timer_dev_tick #(
        .PrescaleWidth(PrescaleWidth)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (ctrl_en),
        .prescale_i(prescale),
        .clr_i     (wr_prescale),
        .tick_o    (tick)
    );

    // Register file: bus writes to mtime take priority over the tick, and a
    // LO read snapshots the upper half for a later coherent HI read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime     <= '0;
            mtimecmp  <= CmpResetVal;
            prescale  <= '0;
            ctrl_en   <= 1'b0;
            hi_shadow <= '0;
        end else begin
            if (wr_mtime_lo) begin
                mtime[31:0] <= wmerge;
            end else if (wr_mtime_hi) begin
                mtime[TimeWidth-1:32] <= wmerge[HiWidth-1:0];
            end else if (tick) begin
                mtime <= mtime + TimeWidth'(1);
            end
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= wmerge;
            end
            if (wr_cmp_hi) begin
                mtimecmp[TimeWidth-1:32] <= wmerge[HiWidth-1:0];
            end
            if (wr_prescale) begin
                prescale <= wmerge[PrescaleWidth-1:0];
            end
            if (wr_ctrl) begin
                ctrl_en <= wmerge[CTRL_EN_BIT];
            end
            if (rd_act && (off == OFF_MTIME_LO)) begin
                hi_shadow <= mtime[TimeWidth-1:32];
            end
        end
    end

    // ---- stage p1: bus response, one cycle after every request ----
    // Respond to each request next cycle; rdata is zero for writes and errors.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1   <= dev_req_i;
            err_p1   <= dev_req_i && !hit;
            rdata_p1 <= rd_act ? rd_word : '0;
        end
    end

    // Registered unsigned compare of the current mtime against mtimecmp.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_p1 <= 1'b0;
        end else begin
            irq_p1 <= (mtime >= mtimecmp);
        end
    end

    assign dev_rvalid_o = vld_p1;
    assign dev_err_o    = err_p1;
    assign dev_rdata_o  = rdata_p1;
    assign timer_irq_o  = irq_p1;

endmodule

// File: tb/tb_sim_timer_dev.sv
// Self-checking bench for sim_timer_dev: a transaction-level model of the
// timer predicts every output each cycle, and directed sequences pin it with
// hand-computed values.
module tb_sim_timer_dev;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        irq;

    int checks = 0;
    int failures = 0;

    sim_timer_dev dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .dev_req_i   (req),
        .dev_we_i    (we),
        .dev_addr_i  (addr),
        .dev_be_i    (be),
        .dev_wdata_i (wdata),
        .dev_rvalid_o(rvalid),
        .dev_rdata_o (rdata),
        .dev_err_o   (err),
        .timer_irq_o (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_shadow;
    logic [15:0] m_pre;
    int unsigned m_phase;
    logic        m_en;
    logic        exp_vld, exp_err, exp_irq;
    logic [31:0] exp_rdata;

    task automatic model_reset();
        m_time = '0; m_cmp = '1; m_shadow = '0; m_pre = '0; m_phase = 0; m_en = 1'b0;
        exp_vld = 1'b0; exp_err = 1'b0; exp_irq = 1'b0; exp_rdata = '0;
    endtask

    task automatic model_step();
        logic [9:0]  o;
        logic        hit, wr, tick;
        logic [31:0] cur, mg;
        o   = addr[9:0];
        hit = (o inside {10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014});
        wr  = req && we && hit && (be != 4'b0);
        exp_irq   = (m_time >= m_cmp);
        exp_vld   = req;
        exp_err   = req && !hit;
        exp_rdata = '0;
        case (o)
            10'h000: cur = m_time[31:0];
            10'h004: cur = m_time[63:32];
            10'h008: cur = m_cmp[31:0];
            10'h00C: cur = m_cmp[63:32];
            10'h010: cur = {16'h0, m_pre};
            10'h014: cur = {31'b0, m_en};
            default: cur = '0;
        endcase
        if (req && !we && hit) begin
            exp_rdata = (o == 10'h004) ? m_shadow : cur;
            if (o == 10'h000) m_shadow = m_time[63:32];
        end
        mg = cur;
        for (int i = 0; i < 4; i++) if (be[i]) mg[8*i +: 8] = wdata[8*i +: 8];
        // mtime advances once every (prescale+1) enabled cycles
        tick = 1'b0;
        if (wr && o == 10'h010) begin
            m_phase = 0;
        end else if (m_en) begin
            m_phase = (m_phase + 1) % (int'(m_pre) + 1);
            tick = (m_phase == 0);
        end
        if (wr && o == 10'h000)      m_time[31:0]  = mg;
        else if (wr && o == 10'h004) m_time[63:32] = mg;
        else if (tick)               m_time        = m_time + 64'd1;
        if (wr && o == 10'h008) m_cmp[31:0]  = mg;
        if (wr && o == 10'h00C) m_cmp[63:32] = mg;
        if (wr && o == 10'h010) m_pre = mg[15:0];
        if (wr && o == 10'h014) m_en  = mg[0];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every cycle: outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_rvalid", rvalid, exp_vld);
            chk("cyc_rdata", rdata, exp_rdata);
            chk("cyc_err", err, exp_err);
            chk("cyc_irq", irq, exp_irq);
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd, output logic e);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        rd = rdata; e = err;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; logic e;
        bus(1'b1, a, 4'hF, d, r, e);
    endtask

    task automatic rd32(input logic [31:0] a, output logic [31:0] r);
        logic e;
        bus(1'b0, a, 4'h0, 32'h0, r, e);
    endtask

    localparam logic [31:0] A_LO = 32'h00, A_HI = 32'h04, A_CLO = 32'h08, A_CHI = 32'h0C,
                            A_PRE = 32'h10, A_CTRL = 32'h14;

    initial begin
        logic [31:0] v;
        logic [31:0] seq [8];
        logic [31:0] exp_seq [8];
        logic        e;
        exp_seq = '{32'd10, 32'd10, 32'd10, 32'd11, 32'd11, 32'd11, 32'd11, 32'd12};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset values
        chk("rst_irq", irq, 1'b0);
        rd32(A_LO, v);   chk("rst_mtime_lo", v, 32'h0);
        rd32(A_HI, v);   chk("rst_mtime_hi", v, 32'h0);
        rd32(A_CLO, v);  chk("rst_cmp_lo", v, 32'hFFFF_FFFF);
        rd32(A_CHI, v);  chk("rst_cmp_hi", v, 32'hFFFF_FFFF);
        rd32(A_PRE, v);  chk("rst_prescale", v, 32'h0);
        bus(1'b0, A_CTRL, 4'h0, 32'h0, v, e);
        chk("rst_ctrl", v, 32'h0); chk("rst_err", e, 1'b0);

        // prescale 3: one tick every 4 cycles
        wr32(A_PRE, 32'd3);
        wr32(A_CTRL, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        rd32(A_LO, v); chk("pre3_after40", v, 32'd10);
        for (int i = 0; i < 8; i++) rd32(A_LO, seq[i]);
        for (int i = 0; i < 8; i++) chk($sformatf("pre3_seq%0d", i), seq[i], exp_seq[i]);
        wr32(A_CTRL, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        rd32(A_LO, v); chk("frozen", v, 32'd12);

        // carry into HI and shadow coherence, prescale 0
        wr32(A_PRE, 32'd0);
        wr32(A_LO, 32'hFFFF_FFFF);
        wr32(A_HI, 32'h0);
        wr32(A_CTRL, 32'd1);
        rd32(A_LO, v); chk("pair1_lo", v, 32'hFFFF_FFFF);
        rd32(A_HI, v); chk("pair1_hi", v, 32'h0);
        rd32(A_LO, v); chk("pair2_lo", v, 32'h1);
        rd32(A_HI, v); chk("pair2_hi", v, 32'h1);
        rd32(A_LO, v); chk("pair3_lo", v, 32'h3);
        wr32(A_HI, 32'h55);
        rd32(A_HI, v); chk("shadow_kept", v, 32'h1);
        rd32(A_LO, v); chk("hi_write_no_inc", v, 32'h5);
        rd32(A_HI, v); chk("hi_written", v, 32'h55);
        wr32(A_LO, 32'h100);
        rd32(A_LO, v); chk("lo_write_wins", v, 32'h100);
        rd32(A_LO, v); chk("lo_resume", v, 32'h101);
        wr32(A_CTRL, 32'd0);

        // wrap from all ones
        wr32(A_LO, 32'hFFFF_FFFF);
        wr32(A_HI, 32'hFFFF_FFFF);
        wr32(A_CTRL, 32'd1);
        rd32(A_LO, v); chk("wrap_lo0", v, 32'hFFFF_FFFF);
        rd32(A_HI, v); chk("wrap_hi0", v, 32'hFFFF_FFFF);
        rd32(A_LO, v); chk("wrap_lo1", v, 32'h1);
        rd32(A_HI, v); chk("wrap_hi1", v, 32'h0);
        wr32(A_CTRL, 32'd0);

        // interrupt rise and fall
        wr32(A_HI, 32'h0);
        wr32(A_LO, 32'h1E);
        wr32(A_CLO, 32'h20);
        wr32(A_CHI, 32'h0);
        wr32(A_CTRL, 32'd1);
        chk("irq_e0", irq, 1'b0);
        @(posedge clk); #1; chk("irq_e1", irq, 1'b0);
        @(posedge clk); #1; chk("irq_e2", irq, 1'b0);
        @(posedge clk); #1; chk("irq_e3", irq, 1'b1);
        wr32(A_CLO, 32'h100);
        chk("irq_cmp_edge", irq, 1'b1);
        @(posedge clk); #1; chk("irq_fall", irq, 1'b0);
        wr32(A_CTRL, 32'd0);

        // errors and byte enables
        bus(1'b0, 32'h18, 4'h0, 32'h0, v, e);  chk("err18", e, 1'b1); chk("err18_data", v, 32'h0);
        bus(1'b0, 32'h02, 4'h0, 32'h0, v, e);  chk("err02", e, 1'b1); chk("err02_data", v, 32'h0);
        bus(1'b1, 32'h3FC, 4'hF, 32'h1234_5678, v, e); chk("err3fc", e, 1'b1);
        rd32(A_CLO, v); chk("cmp_unchanged", v, 32'h100);
        bus(1'b1, A_CLO, 4'b0010, 32'hAABB_CCDD, v, e); chk("be_write_err", e, 1'b0);
        rd32(A_CLO, v); chk("be_byte1", v, 32'h0000_CC00);
        bus(1'b1, A_CTRL, 4'b0000, 32'h1, v, e);
        rd32(A_CTRL, v); chk("be0_noop", v, 32'h0);
        wr32(A_PRE, 32'hFFFF_FFFF);
        rd32(A_PRE, v); chk("pre_width", v, 32'h0000_FFFF);
        wr32(A_PRE, 32'h0);

        // asynchronous reset with a request pending
        wr32(A_CLO, 32'h0);
        @(posedge clk); #1;
        chk("irq_before_rst", irq, 1'b1);
        rd32(A_CLO, v);
        req = 1'b1; we = 1'b0; addr = A_LO;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rvalid", rvalid, 1'b0);
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_err", err, 1'b0);
        chk("arst_irq", irq, 1'b0);
        @(posedge clk); #1;
        chk("rst_no_rvalid", rvalid, 1'b0);
        req = 1'b0; addr = '0;
        rst_n = 1'b1;
        rd32(A_CLO, v); chk("post_rst_cmp", v, 32'hFFFF_FFFF);
        rd32(A_LO, v);  chk("post_rst_mtime", v, 32'h0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
